// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the
// associative icache controller states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef logic [1:0] istate_assoc_t;

  localparam istate_assoc_t IDLE  = 2'd0;
  localparam istate_assoc_t FILL  = 2'd1;
  localparam istate_assoc_t FLUSH = 2'd2;

endpackage

// File: rtl/icache_assoc_if.sv
// Icache <-> memory arbiter read channel:
// word accepted on iREN & !iwait.
interface icache_assoc_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport master (
    output iREN,
    output iaddr,
    input  iwait,
    input  iload
  );

  modport slave (
    input  iREN,
    input  iaddr,
    output iwait,
    output iload
  );

endinterface

// File: rtl/icache_plru.sv
// Tree pseudo-LRU for one set: bits point at
// the victim side; touching a way points away.
module icache_plru #(
  parameter  int WAYS = 2,
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int PB   = (WAYS > 1) ? WAYS - 1 : 1
) (
  input  logic [PB-1:0] bits_i,
  input  logic [WW-1:0] way_i,
  output logic [WW-1:0] victim_o,
  output logic [PB-1:0] bits_o
);

  generate
    if (WAYS == 4) begin : g_four
      // bit0 selects pair, bit1/bit2 select within pair
      always_comb begin
        victim_o = bits_i[0] ? {1'b1, bits_i[2]}
                             : {1'b0, bits_i[1]};
        bits_o    = bits_i;
        bits_o[0] = ~way_i[1];
        if (way_i[1]) bits_o[2] = ~way_i[0];
        else          bits_o[1] = ~way_i[0];
      end
    end else if (WAYS == 2) begin : g_two
      assign victim_o = bits_i;
      assign bits_o   = ~way_i;
    end else begin : g_one
      logic unused_way;
      assign unused_way = ^way_i;
      assign victim_o   = '0;
      assign bits_o     = bits_i;
    end
  endgenerate

endmodule

// File: rtl/icache_assoc.sv
// Set-associative multi-word-block icache with
// tree-PLRU replacement, burst fill and set-walking flush.
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int WORDS = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  logic  iflush,
  output logic  ihit,
  output word_t imemload,
  output logic  flush_done,
  icache_assoc_if.master mem
);

  localparam int IDX_W = $clog2(SETS);
  localparam int BLK_W = $clog2(WORDS);
  localparam int TAG_W = 30 - IDX_W - BLK_W;
  localparam int BW    = (BLK_W > 0) ? BLK_W : 1;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PB    = (WAYS > 1) ? WAYS - 1 : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } frame_t;

  frame_t        fr;
  logic [BW-1:0] blk;
  logic          unused_addr;

  assign fr  = frame_t'(imemaddr[31 -: TAG_W+IDX_W]);
  assign blk = (WORDS > 1) ? imemaddr[2 +: BW] : '0;
  assign unused_addr = ^imemaddr[1:0];

  word_t            data_q  [WAYS][SETS][WORDS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [PB-1:0]    plru_q  [SETS];

  istate_assoc_t    state_q, state_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] fcnt_q, fcnt_d;
  logic [WW-1:0]    victim_q, victim_d;
  frame_t           lfr_q, lfr_d;
  logic             pend_q, pend_d;

  logic idle, filling, flushing;
  logic accessing, start_fill;
  logic fill_last, flush_last;

  assign idle     = (state_q == IDLE);
  assign filling  = (state_q == FILL);
  assign flushing = (state_q == FLUSH);
  assign accessing = dmemREN | dmemWEN;

  logic [WAYS-1:0] vset, match;
  logic [WW-1:0]   hit_way, inv_way;
  logic            any_inv;

  // downward scan leaves the lowest matching / invalid way
  always_comb begin
    vset    = valid_q[fr.idx];
    match   = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match[w] = vset[w] &&
                 (tag_q[w][fr.idx] == fr.tag);
      if (match[w]) hit_way = WW'(w);
      if (!vset[w]) begin
        inv_way = WW'(w);
        any_inv = 1'b1;
      end
    end
  end

  assign ihit = idle & imemREN & ~accessing &
                ~iflush & (|match);

  assign imemload = ihit ?
    data_q[hit_way][fr.idx][blk] : '0;

  assign start_fill = idle & ~iflush & imemREN &
                      ~accessing & ~ihit;

  assign fill_last = filling & ~mem.iwait &
                     (cnt_q == BW'(WORDS - 1));
  assign flush_last = flushing &
                      (fcnt_q == IDX_W'(SETS - 1));

  // hit update and fill update never coincide
  logic [IDX_W-1:0] pidx;
  logic [WW-1:0]    pway, plru_vic;
  logic [PB-1:0]    pnext;

  assign pidx = idle ? fr.idx  : lfr_q.idx;
  assign pway = idle ? hit_way : victim_q;

  icache_plru #(.WAYS(WAYS)) u_plru (
    .bits_i   (plru_q[pidx]),
    .way_i    (pway),
    .victim_o (plru_vic),
    .bits_o   (pnext)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    victim_d = victim_q;
    lfr_d    = lfr_q;
    pend_d   = pend_q;
    unique case (1'b1)
      idle: begin
        if (iflush) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end else if (start_fill) begin
          state_d  = FILL;
          lfr_d    = fr;
          cnt_d    = '0;
          victim_d = any_inv ? inv_way : plru_vic;
        end
      end
      filling: begin
        pend_d = pend_q | iflush;
        if (~mem.iwait) cnt_d = cnt_q + 1'b1;
        if (fill_last) begin
          state_d = (pend_q | iflush) ? FLUSH : IDLE;
          pend_d  = 1'b0;
          fcnt_d  = '0;
          cnt_d   = '0;
        end
      end
      flushing: begin
        fcnt_d = fcnt_q + 1'b1;
        if (flush_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      victim_q <= '0;
      lfr_q    <= '0;
      pend_q   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      victim_q <= victim_d;
      lfr_q    <= lfr_d;
      pend_q   <= pend_d;
      if (start_fill)
        valid_q[fr.idx][victim_d] <= 1'b0;
      if (ihit)
        plru_q[fr.idx] <= pnext;
      if (fill_last) begin
        valid_q[lfr_q.idx][victim_q] <= 1'b1;
        plru_q[lfr_q.idx] <= pnext;
      end
      if (flushing) begin
        valid_q[fcnt_q] <= '0;
        plru_q[fcnt_q]  <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (filling & ~mem.iwait) begin
      data_q[victim_q][lfr_q.idx][cnt_q] <= mem.iload;
      if (fill_last)
        tag_q[victim_q][lfr_q.idx] <= lfr_q.tag;
    end
  end

  assign mem.iREN  = filling;
  assign mem.iaddr = filling ?
    ({lfr_q, {(BLK_W + 2){1'b0}}} | (32'(cnt_q) << 2)) :
    '0;
  assign flush_done = flush_last;

endmodule

// File: tb/tb_icache_assoc.sv
// Random + directed bench for icache_assoc against
// an LRU-timestamp cache model (2 ways, 8 sets, 2 words).
module tb_icache_assoc;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN, dmemREN, dmemWEN, iflush;
  logic  ihit, flush_done;
  word_t imemaddr, imemload;

  icache_assoc_if mem_if ();

  icache_assoc dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .iflush     (iflush),
    .ihit       (ihit),
    .imemload   (imemload),
    .flush_done (flush_done),
    .mem        (mem_if)
  );

  always #5 CLK = ~CLK;

  function automatic word_t memfn(word_t a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ (a >> 3);
  endfunction

  always_comb
    mem_if.iload = mem_if.iREN ?
      memfn(mem_if.iaddr) : 32'hDEAD_BEEF;

  int checks = 0;
  int fails  = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // model: per-way lines, LRU by last-use timestamp
  bit          mv [2][8];
  int unsigned mt [2][8];
  word_t       md [2][8][2];
  int unsigned ms [2][8];
  int unsigned tick;
  int          mode;
  int          wcnt, fidx, vic, lidx;
  int unsigned ltag;
  bit          pend;
  bit          last_hit, dut_hit, dut_fd;

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        mv[w][s] = 0;
        ms[w][s] = 0;
      end
    tick = 0; mode = 0; pend = 0;
    wcnt = 0; fidx = 0;
  endtask

  task automatic step(bit ren, word_t a, bit dr,
                      bit dw, bit fl, bit wt);
    int unsigned tg;
    int idx, blk, hw;
    bit found, eh, er, efd;
    word_t el, ea;
    @(negedge CLK);
    imemREN = ren; imemaddr = a;
    dmemREN = dr;  dmemWEN = dw;
    iflush = fl;   mem_if.iwait = wt;
    #1;
    tg  = a >> 6;
    idx = (a >> 3) % 8;
    blk = (a >> 2) % 2;
    found = 0; hw = 0;
    for (int w = 1; w >= 0; w--)
      if (mv[w][idx] && mt[w][idx] == tg) begin
        found = 1; hw = w;
      end
    eh = 0; el = 0; er = 0; ea = 0; efd = 0;
    if (mode == 0) begin
      eh = ren && !(dr || dw) && !fl && found;
      if (eh) el = md[hw][idx][blk];
    end else if (mode == 1) begin
      er = 1;
      ea = (ltag << 6) | (lidx << 3) | (wcnt << 2);
    end else begin
      efd = (fidx == 7);
    end
    chk("ihit", ihit, eh);
    chk("imemload", imemload, el);
    chk("iREN", mem_if.iREN, er);
    chk("iaddr", mem_if.iaddr, ea);
    chk("flush_done", flush_done, efd);
    last_hit = eh;
    dut_hit  = ihit;
    dut_fd   = flush_done;
    case (mode)
      0: begin
        if (fl) begin
          mode = 2; fidx = 0;
        end else if (ren && !(dr || dw) && !found) begin
          vic = -1;
          for (int w = 0; w < 2; w++)
            if (!mv[w][idx] && vic < 0) vic = w;
          if (vic < 0)
            vic = (ms[0][idx] <= ms[1][idx]) ? 0 : 1;
          mv[vic][idx] = 0;
          mode = 1; ltag = tg; lidx = idx; wcnt = 0;
        end else if (eh) begin
          tick++;
          ms[hw][idx] = tick;
        end
      end
      1: begin
        pend |= fl;
        if (!wt) begin
          md[vic][lidx][wcnt] = memfn(ea);
          wcnt++;
          if (wcnt == 2) begin
            mv[vic][lidx] = 1;
            mt[vic][lidx] = ltag;
            tick++;
            ms[vic][lidx] = tick;
            mode = pend ? 2 : 0;
            pend = 0; fidx = 0;
          end
        end
      end
      default: begin
        for (int w = 0; w < 2; w++) begin
          mv[w][fidx] = 0;
          ms[w][fidx] = 0;
        end
        fidx++;
        if (fidx == 8) mode = 0;
      end
    endcase
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch(word_t a, int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      step(1, a, 0, 0, 0, 0);
      if (last_hit) begin
        got = 1;
        break;
      end
    end
    chk("fetch_budget", got, 1);
  endtask

  task automatic flush_wait(string tag);
    bit seen;
    int n;
    seen = 0; n = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
      seen = dut_fd;
    end
    chk(tag, n, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 0; imemREN = 0; imemaddr = 0;
    dmemREN = 0; dmemWEN = 0; iflush = 0;
    mem_if.iwait = 0;
    model_reset();
    #12;
    chk("rst_ihit", ihit, 0);
    chk("rst_imemload", imemload, 0);
    chk("rst_iREN", mem_if.iREN, 0);
    chk("rst_iaddr", mem_if.iaddr, 0);
    chk("rst_flush_done", flush_done, 0);
    @(negedge CLK);
    nRST = 1;

    // cold miss, two-word burst, replay hit
    step(1, 32'h40, 0, 0, 0, 0);
    chk("t1_miss", dut_hit, 0);
    step(1, 32'h40, 0, 0, 0, 0);
    step(1, 32'h40, 0, 0, 0, 0);
    step(1, 32'h40, 0, 0, 0, 0);
    chk("t1_hit", dut_hit, 1);
    step(1, 32'h44, 0, 0, 0, 0);
    chk("t2_same_block_hit", dut_hit, 1);

    // same set, third tag evicts LRU way
    fetch(32'h440, 8);
    fetch(32'h040, 8);
    fetch(32'h840, 8);
    step(1, 32'h040, 0, 0, 0, 0);
    chk("t3_040_kept", dut_hit, 1);
    step(1, 32'h440, 0, 0, 0, 0);
    chk("t3_440_evicted", dut_hit, 0);
    fetch(32'h440, 8);

    // data-side access suppresses hit and miss
    step(1, 32'h040, 1, 0, 0, 0);
    chk("t4_dmemREN_nohit", dut_hit, 0);
    step(1, 32'h040, 0, 1, 0, 0);
    step(1, 32'h1000, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1);
    step(1, 32'h2000, 1, 0, 0, 0);
    step(1, 32'h1004, 0, 0, 0, 0);
    chk("t4_fill_completed", dut_hit, 1);

    // flush from idle, then everything misses
    step(1, 32'h040, 0, 0, 1, 0);
    chk("t5_flush_cycle_nohit", dut_hit, 0);
    flush_wait("t5_flush_len");
    step(1, 32'h440, 0, 0, 0, 0);
    chk("t5_after_flush_miss", dut_hit, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    flush_wait("t5_pending_flush_len");
    step(1, 32'h440, 0, 0, 0, 0);
    chk("t5_pending_flushed", dut_hit, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++)
      step(0, 0, 0, 0, i == 3, 0);
    chk("t5_flush_done_last", dut_fd, 1);

    // async reset in the middle of a fill
    step(1, 32'h2040, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    mem_if.iwait = 0;
    #2;
    chk("t6_pre_rst_iREN", mem_if.iREN, 1);
    chk("t6_pre_rst_iaddr", mem_if.iaddr, 32'h2044);
    nRST = 0;
    #1;
    chk("t6_rst_iREN", mem_if.iREN, 0);
    chk("t6_rst_iaddr", mem_if.iaddr, 0);
    model_reset();
    @(negedge CLK);
    nRST = 1;
    step(1, 32'h2044, 0, 0, 0, 0);
    chk("t6_refetch_miss", dut_hit, 0);
    fetch(32'h2044, 8);

    // randomized traffic over a small address pool
    for (int i = 0; i < 1500; i++) begin
      word_t a;
      a = ($urandom_range(0, 3) << 6) |
          ($urandom_range(0, 7) << 3) |
          ($urandom_range(0, 1) << 2);
      step($urandom_range(0, 9) < 8, a,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 9) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
